// File: rtl/periph_timer_responder.sv
// Peripheral bus responder: 64-bit free-running timer with compare/irq, status and scratch registers.
// Optional macro PERIPH_TIMER_PRESCALE_EN adds a 16-bit tick prescaler register at offset 0x28.
package structures;
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    BYTE  = 3'd1,
    HALF  = 3'd2,
    WORD  = 3'd3,
    DWORD = 3'd4
  } mem_store_type_t;
endpackage

module periph_timer_responder
  import structures::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h2000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  input  mem_store_type_t d_store_type,
  input  logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_ready,
  output logic            irq
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [4:0] IDX_CTRL     = 5'd0;
  localparam logic [4:0] IDX_COUNT    = 5'd1;
  localparam logic [4:0] IDX_COMPARE  = 5'd2;
  localparam logic [4:0] IDX_STATUS   = 5'd3;
  localparam logic [4:0] IDX_SCRATCH  = 5'd4;
  localparam logic [4:0] IDX_PRESCALE = 5'd5;

  state_t          r_state, w_next;
  logic [3:0]      r_wcnt;
  logic [7:0]      r_addr;
  logic [63:0]     r_wdata;
  mem_store_type_t r_stype;

  logic [2:0]      r_ctrl;
  logic [63:0]     r_count, r_compare, r_scratch;
  logic            r_pending, r_irq;

  logic            w_sel, w_commit, w_aligned, w_we, w_tick, w_match;
  logic [7:0]      w_addr, w_bmask;
  logic [63:0]     w_wdata, w_wshift, w_wmask, w_old, w_merged;
  mem_store_type_t w_stype;
  logic [63:0]     w_regs [8];

`ifdef PERIPH_TIMER_PRESCALE_EN
  logic [15:0]     r_prescale, r_psc;
`endif

  assign w_sel = d_valid && (d_addr[63:8] == BASE_ADDR[63:8]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_sel) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (r_wcnt <= 4'd1) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wcnt  <= 4'd0;
      r_addr  <= 8'd0;
      r_wdata <= 64'd0;
      r_stype <= NONE;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_sel) begin
        r_wcnt  <= 4'(WAIT_STATES);
        r_addr  <= d_addr[7:0];
        r_wdata <= d_wdata;
        r_stype <= d_store_type;
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
    end
  end

  // With zero wait states the commit edge is also the acceptance edge, so use the live request.
  assign w_addr   = (r_state == IDLE) ? d_addr[7:0]  : r_addr;
  assign w_wdata  = (r_state == IDLE) ? d_wdata      : r_wdata;
  assign w_stype  = (r_state == IDLE) ? d_store_type : r_stype;
  assign w_commit = (r_state != RESP) && (w_next == RESP);

  always_comb begin
    w_aligned = 1'b0;
    w_bmask   = 8'h00;
    case (w_stype)
      BYTE:  begin w_aligned = 1'b1;                   w_bmask = 8'h01 << w_addr[2:0]; end
      HALF:  begin w_aligned = (w_addr[0] == 1'b0);    w_bmask = 8'h03 << w_addr[2:0]; end
      WORD:  begin w_aligned = (w_addr[1:0] == 2'b00); w_bmask = 8'h0F << w_addr[2:0]; end
      DWORD: begin w_aligned = (w_addr[2:0] == 3'b000); w_bmask = 8'hFF;               end
      default: ;
    endcase
    for (int i = 0; i < 8; i++) w_wmask[8*i +: 8] = {8{w_bmask[i]}};
  end

  assign w_wshift = w_wdata << {w_addr[2:0], 3'b000};
  assign w_we     = w_commit && (w_stype != NONE) && w_aligned;

  always_comb begin
    w_regs[0] = {61'd0, r_ctrl};
    w_regs[1] = r_count;
    w_regs[2] = r_compare;
    w_regs[3] = {63'd0, r_pending};
    w_regs[4] = r_scratch;
`ifdef PERIPH_TIMER_PRESCALE_EN
    w_regs[5] = {48'd0, r_prescale};
`else
    w_regs[5] = 64'd0;
`endif
    w_regs[6] = 64'd0;
    w_regs[7] = 64'd0;
  end

  assign w_old    = (w_addr[7:6] == 2'b00) ? w_regs[w_addr[5:3]] : 64'd0;
  assign w_merged = (w_old & ~w_wmask) | (w_wshift & w_wmask);

  assign d_ready = (r_state == RESP);
  assign d_rdata = (d_ready && r_addr[7:6] == 2'b00) ? w_regs[r_addr[5:3]] : 64'd0;
  assign irq     = r_irq;

`ifdef PERIPH_TIMER_PRESCALE_EN
  assign w_tick = r_ctrl[0] && (r_psc == r_prescale);
`else
  assign w_tick = r_ctrl[0];
`endif
  assign w_match = w_tick && (r_count == r_compare);

  // Bus writes to COUNT override the tick; a match setting pending overrides a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctrl    <= 3'd0;
      r_count   <= 64'd0;
      r_compare <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_scratch <= 64'd0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_we && w_addr[7:3] == IDX_COUNT)  r_count <= w_merged;
      else if (w_match && r_ctrl[1])         r_count <= 64'd0;
      else if (w_tick)                       r_count <= r_count + 64'd1;

      if (w_match) r_pending <= 1'b1;
      else if (w_we && w_addr[7:3] == IDX_STATUS && w_wmask[0] && w_wshift[0]) r_pending <= 1'b0;

      if (w_we && w_addr[7:3] == IDX_CTRL)    r_ctrl    <= w_merged[2:0];
      if (w_we && w_addr[7:3] == IDX_COMPARE) r_compare <= w_merged;
      if (w_we && w_addr[7:3] == IDX_SCRATCH) r_scratch <= w_merged;
      r_irq <= r_pending & r_ctrl[2];
    end
  end

`ifdef PERIPH_TIMER_PRESCALE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prescale <= 16'd0;
      r_psc      <= 16'd0;
    end else if (w_we && w_addr[7:3] == IDX_PRESCALE) begin
      r_prescale <= w_merged[15:0];
      r_psc      <= 16'd0;
    end else if (!r_ctrl[0] || w_tick) begin
      r_psc <= 16'd0;
    end else begin
      r_psc <= r_psc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_periph_timer_responder.sv
// Self-checking bench for periph_timer_responder: directed scenarios plus randomized bus traffic
// compared against a cycle-level behavioural register/timer model.
module tb_periph_timer_responder;
  import structures::*;

  localparam logic [63:0] BASE = 64'h2000_0000;
  localparam int          WS   = 1;

  logic            clock, reset, d_valid, d_ready, irq;
  logic [63:0]     d_addr, d_wdata, d_rdata;
  mem_store_type_t d_store_type;

  int checkCount = 0;
  int errorCount = 0;

  logic [2:0]  mCtrl;
  logic [63:0] mCnt, mCmp, mScr;
  logic        mPend, mIrq;
  int          mCommitIn;
  logic [7:0]  reqAddr;
  logic [2:0]  reqType;
  logic [63:0] reqData;
`ifdef PERIPH_TIMER_PRESCALE_EN
  logic [15:0] mPre, mPsc;
`endif

  periph_timer_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_store_type(d_store_type), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_ready(d_ready), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mCtrl = 3'd0; mCnt = 64'd0; mCmp = 64'hFFFF_FFFF_FFFF_FFFF; mScr = 64'd0;
    mPend = 1'b0; mIrq = 1'b0; mCommitIn = 0;
`ifdef PERIPH_TIMER_PRESCALE_EN
    mPre = 16'd0; mPsc = 16'd0;
`endif
  endtask

  function automatic logic [63:0] mdlRead(input logic [4:0] idx);
    case (idx)
      5'd0: return {61'd0, mCtrl};
      5'd1: return mCnt;
      5'd2: return mCmp;
      5'd3: return {63'd0, mPend};
      5'd4: return mScr;
`ifdef PERIPH_TIMER_PRESCALE_EN
      5'd5: return {48'd0, mPre};
`endif
      default: return 64'd0;
    endcase
  endfunction

  function automatic int sizeOf(input logic [2:0] st);
    case (st)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] mergeWrite(input logic [63:0] old, input logic [2:0] off,
                                             input logic [2:0] st, input logic [63:0] data);
    logic [63:0] v;
    int o;
    v = old;
    o = int'(off);
    for (int i = 0; i < sizeOf(st); i++) v[8*(o+i) +: 8] = data[8*i +: 8];
    return v;
  endfunction

  // One clock edge of the reference: timer rules, then any bus write committing on this edge.
  task automatic modelEdge();
    logic tick, match, nPend, nIrq;
    logic [2:0] nCtrl;
    logic [63:0] nCnt, nCmp, nScr, merged, clrBits;
`ifdef PERIPH_TIMER_PRESCALE_EN
    logic [15:0] nPre, nPsc;
    tick = mCtrl[0] && (mPsc == mPre);
    nPsc = (!mCtrl[0] || tick) ? 16'd0 : mPsc + 16'd1;
    nPre = mPre;
`else
    tick = mCtrl[0];
`endif
    nIrq  = mPend & mCtrl[2];
    match = tick && (mCnt == mCmp);
    nCnt  = !tick ? mCnt : ((match && mCtrl[1]) ? 64'd0 : mCnt + 64'd1);
    nPend = mPend | match;
    nCtrl = mCtrl; nCmp = mCmp; nScr = mScr;
    if (mCommitIn > 0) begin
      mCommitIn--;
      if (mCommitIn == 0 && reqType != 3'd0 && (int'(reqAddr[2:0]) % sizeOf(reqType)) == 0) begin
        merged  = mergeWrite(mdlRead(reqAddr[7:3]), reqAddr[2:0], reqType, reqData);
        clrBits = mergeWrite(64'd0, reqAddr[2:0], reqType, reqData);
        case (reqAddr[7:3])
          5'd0: nCtrl = merged[2:0];
          5'd1: nCnt  = merged;
          5'd2: nCmp  = merged;
          5'd3: if (clrBits[0] && !match) nPend = 1'b0;
          5'd4: nScr  = merged;
`ifdef PERIPH_TIMER_PRESCALE_EN
          5'd5: begin nPre = merged[15:0]; nPsc = 16'd0; end
`endif
          default: ;
        endcase
      end
    end
    mCtrl = nCtrl; mCnt = nCnt; mCmp = nCmp; mScr = nScr; mPend = nPend; mIrq = nIrq;
`ifdef PERIPH_TIMER_PRESCALE_EN
    mPre = nPre; mPsc = nPsc;
`endif
  endtask

  task automatic stepClock();
    @(posedge clock);
    if (reset) modelEdge();
    @(negedge clock);
    checkOutput("irq", 64'(irq), 64'(mIrq));
  endtask

  // One in-window transaction, driven from a negedge; returns the data seen with d_ready.
  task automatic applyStimulus(input logic [63:0] addr, input logic [2:0] st,
                               input logic [63:0] data, output logic [63:0] rd);
    int n;
    d_addr = addr; d_wdata = data; d_store_type = mem_store_type_t'(st); d_valid = 1'b1;
    reqAddr = addr[7:0]; reqType = st; reqData = data; mCommitIn = WS + 1;
    n = 0;
    do begin
      stepClock();
      n++;
    end while (!d_ready && n < 40);
    checkOutput("latency", 64'(n), 64'(WS + 1));
    rd = d_rdata;
    checkOutput("rdata", d_rdata, mdlRead(reqAddr[7:3]));
    d_valid = 1'b0; d_store_type = NONE;
    stepClock();
    checkOutput("ready_pulse", 64'(d_ready), 64'd0);
    checkOutput("rdata_idle", d_rdata, 64'd0);
  endtask

  task automatic outOfWindow(input int cycles);
    d_addr = BASE + 64'h100; d_store_type = NONE; d_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      stepClock();
      checkOutput("oow_ready", 64'(d_ready), 64'd0);
    end
    d_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    reset = 1'b0; d_valid = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_store_type = NONE;
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput("reset_ready", 64'(d_ready), 64'd0);
    checkOutput("reset_rdata", d_rdata, 64'd0);
    checkOutput("reset_irq", 64'(irq), 64'd0);
    reset = 1'b1;

    applyStimulus(BASE + 64'h10, 3'd0, 64'd0, rd);
    checkOutput("reset_compare", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(BASE + 64'h20, 3'd4, 64'h1234, rd);
    applyStimulus(BASE + 64'h20, 3'd0, 64'd0, rd);
    checkOutput("scratch_rd", rd, 64'h1234);

    applyStimulus(BASE + 64'h20, 3'd4, 64'd0, rd);
    applyStimulus(BASE + 64'h23, 3'd1, 64'hAB, rd);
    applyStimulus(BASE + 64'h20, 3'd0, 64'd0, rd);
    checkOutput("byte_merge", rd, 64'h0000_0000_AB00_0000);
    applyStimulus(BASE + 64'h22, 3'd3, 64'hFFFF_FFFF, rd);
    applyStimulus(BASE + 64'h20, 3'd0, 64'd0, rd);
    checkOutput("misaligned_drop", rd, 64'h0000_0000_AB00_0000);

    applyStimulus(BASE + 64'h10, 3'd4, 64'd5, rd);
    applyStimulus(BASE + 64'h08, 3'd4, 64'd0, rd);
    applyStimulus(BASE + 64'h00, 3'd4, 64'd7, rd);
    repeat (10) stepClock();
    applyStimulus(BASE + 64'h18, 3'd0, 64'd0, rd);
    checkOutput("status_set", rd, 64'd1);
    checkOutput("irq_set", 64'(irq), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(BASE + 64'h08, 3'd0, 64'd0, rd);
    applyStimulus(BASE + 64'h18, 3'd4, 64'd1, rd);
    repeat (8) stepClock();

    outOfWindow(10);
    applyStimulus(BASE + 64'h40, 3'd0, 64'd0, rd);
    checkOutput("unmapped_rd", rd, 64'd0);

    d_addr = BASE + 64'h20; d_wdata = 64'hDEAD_BEEF; d_store_type = DWORD; d_valid = 1'b1;
    reqAddr = 8'h20; reqType = 3'd4; reqData = 64'hDEAD_BEEF; mCommitIn = WS + 1;
    stepClock();
    reset = 1'b0; d_valid = 1'b0; d_store_type = NONE;
    modelReset();
    repeat (2) begin
      stepClock();
      checkOutput("rst_ready", 64'(d_ready), 64'd0);
    end
    reset = 1'b1;
    applyStimulus(BASE + 64'h20, 3'd0, 64'd0, rd);
    checkOutput("rst_scratch", rd, 64'd0);
    applyStimulus(BASE + 64'h10, 3'd0, 64'd0, rd);
    checkOutput("rst_compare", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(BASE + 64'h00, 3'd4, 64'd1, rd);
    repeat (3) stepClock();
    applyStimulus(BASE + 64'h08, 3'd4, 64'd100, rd);
    applyStimulus(BASE + 64'h08, 3'd0, 64'd0, rd);
    checkOutput("count_ge100", 64'(rd >= 64'd100), 64'd1);

`ifdef PERIPH_TIMER_PRESCALE_EN
    applyStimulus(BASE + 64'h28, 3'd4, 64'd3, rd);
    applyStimulus(BASE + 64'h08, 3'd4, 64'd0, rd);
    for (int i = 0; i < 4; i++) begin
      repeat (i + 1) stepClock();
      applyStimulus(BASE + 64'h08, 3'd0, 64'd0, rd);
    end
`else
    applyStimulus(BASE + 64'h28, 3'd4, 64'hFFFF, rd);
    applyStimulus(BASE + 64'h28, 3'd0, 64'd0, rd);
    checkOutput("prescale_absent", rd, 64'd0);
`endif

    for (int t = 0; t < 80; t++) begin
      int idx;
      logic [2:0] off, st;
      logic [63:0] data;
      idx = int'($urandom_range(0, 6));
      off = 3'($urandom_range(0, 7));
      st  = 3'($urandom_range(0, 4));
      case (idx)
        0:       data = 64'($urandom_range(0, 7));
        1, 2:    data = 64'($urandom_range(0, 30));
        5:       data = 64'($urandom_range(0, 3));
        default: data = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 9) == 0) outOfWindow(3);
      else applyStimulus(BASE + 64'(idx * 8) + 64'(off), st, data, rd);
      repeat ($urandom_range(0, 3)) stepClock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/periph_timer_responder.md
Name: periph_timer_responder

Overview:
- Memory-mapped peripheral responder on the core's peripheral data port (d_addr/d_wdata/d_rdata/d_store_type/d_valid/d_ready); it is the target end of that handshake.
- Contains a 64-bit free-running timer with compare match, a status register and a scratch register.
- Its irq output drives one bit of the core's interrupt_sources.
- Several responders share the port; each answers only inside its own address window.

Parameters:
- BASE_ADDR, 64'h2000_0000, window base; window is BASE_ADDR..BASE_ADDR+0xFF.
- WAIT_STATES, 1, extra cycles between request acceptance and d_ready (0..15).

Ports:
- clock  input  1  single clock.
- reset  input  1  asynchronous, active-low (0 = reset).
- d_addr  input  64  request byte address.
- d_wdata  input  64  write data, right-aligned to lane 0.
- d_store_type  input  mem_store_type_t  from the structures package; NONE = read; BYTE/HALF/WORD/DWORD = write width.
- d_valid  input  1  request present, held until d_ready.
- d_rdata  output  64  read data, valid while d_ready=1.
- d_ready  output  1  one-cycle completion pulse.
- irq  output  1  level interrupt.

Behaviour:
- Select:
  - sel = d_valid && d_addr[63:8] == BASE_ADDR[63:8].
  - Out-of-window requests are ignored: no state change, no d_ready.
- FSM states IDLE, WAIT, RESP:
  - IDLE: sel → WAIT with wcnt=WAIT_STATES, or → RESP if WAIT_STATES=0. Request fields are latched at this edge.
  - WAIT: decrement wcnt; at 0 → RESP.
  - RESP: d_ready=1 for exactly one cycle → IDLE.
  - Latency: d_valid first high in cycle 0 gives d_ready high in cycle 1+WAIT_STATES.
  - d_valid high in the cycle after RESP is a new request; back-to-back requests are legal.
- Request changes: d_valid dropping before d_ready is a protocol violation; the FSM still completes using the latched request.
- Writes:
  - Commit on the edge entering RESP, so the new value is readable by the next request.
  - Sub-word writes merge into the 64-bit register at byte lane d_addr[2:0]. HALF uses an aligned 2-byte lane, WORD an aligned 4-byte lane.
  - Misaligned HALF/WORD/DWORD writes are dropped, but d_ready is still given.
- Reads:
  - Full 64-bit register placed on d_rdata in RESP; the core extracts lanes.
  - d_rdata = 0 whenever d_ready=0.
- Register map (offset d_addr[7:3]*8):
  - 0x00 CTRL: [0] enable, [1] auto_reload, [2] irq_en; other bits read 0.
  - 0x08 COUNT.
  - 0x10 COMPARE.
  - 0x18 STATUS: [0] match pending, write-1-to-clear.
  - 0x20 SCRATCH.
  - Other offsets: read 0, writes ignored, d_ready still given (no bus hang).
- Timer:
  - While enable=1, COUNT increments by 1 per tick and wraps 2^64-1 → 0.
  - On a tick where COUNT==COMPARE: pending is set. If auto_reload, the next COUNT is 0; otherwise COUNT increments normally.
- Conflict priorities:
  - Bus write to COUNT beats both the increment and the reload.
  - Match-set of pending beats a W1C in the same cycle.
  - CTRL write takes effect from the next cycle.
- irq: registered, equals pending & irq_en, so it lags by one cycle.
- Reset values:
  - Async reset forces state IDLE, d_ready=0, d_rdata=0, irq=0.
  - CTRL=0, COUNT=0, COMPARE=64'hFFFF_FFFF_FFFF_FFFF, STATUS=0, SCRATCH=0.
  - Reset mid-transaction aborts the request with no d_ready and no write.

Optional Feature:
- Macro: PERIPH_TIMER_PRESCALE_EN.
- Defined:
  - Adds register PRESCALE at 0x28 (16 bits, reset 0).
  - A tick occurs every PRESCALE+1 cycles via an internal counter.
  - The internal counter clears when enable goes 0 or PRESCALE is written.
- Undefined:
  - Tick every cycle.
  - 0x28 reads 0 and writes are ignored.

Test Plan:
- Latency:
  - WAIT_STATES=1, DWORD write 64'h1234 to SCRATCH (0x2000_0020) → d_ready high exactly in cycle 2 for one cycle.
  - Follow-up read → d_rdata=64'h1234 in its d_ready cycle.
- Byte merge: SCRATCH=0; BYTE write 8'hAB to 0x2000_0023 → read returns 64'h0000_0000_AB00_0000. Misaligned WORD write to 0x2000_0022 → value unchanged and d_ready still pulsed.
- Compare and auto-reload:
  - COMPARE=5; CTRL=3'b111 → STATUS[0]=1 and irq=1 one cycle later.
  - COUNT sequence 4,5,0,1.
  - Write STATUS=1 → irq drops.
- Out of window and unmapped: d_valid with d_addr=0x2000_0100 for 10 cycles → d_ready stays 0. Read of 0x2000_0040 → d_ready with d_rdata=0.
- Reset and conflict:
  - Assert reset during WAIT → d_ready stays 0, SCRATCH unchanged, COMPARE=all ones.
  - Write COUNT=100 while enabled → next read ≥100; the bus write beats the increment.
- Prescaler: with PERIPH_TIMER_PRESCALE_EN and PRESCALE=3 → COUNT advances by 1 every 4 cycles. Without the macro → 0x28 reads 0.
